// File: rtl/ps2_rx_scancode.sv
// PS/2 device-to-host receiver: synchronises the pins, frames 11-bit words and holds the last scan code for hex display.
// Optional PS2_RX_TIMEOUT_EN macro adds an abandon-partial-frame timer of TIMEOUT_CYCLES system clocks.
module ps2_rx_scancode #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo,
    output logic       break_flag
);

    // state    | meaning
    // S_IDLE   | waiting for a start bit
    // S_DATA   | shifting in 8 data bits, LSB first
    // S_PARITY | capturing the odd-parity bit
    // S_STOP   | checking stop bit and committing the byte
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_clk_s1, r_clk_s2, r_clk_s3;
    logic        r_dat_s1, r_dat_s2;
    logic        w_fall;
    logic        w_data;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [7:0]  r_code;
    logic        r_code_valid;
    logic        r_frame_err;
    logic [7:0]  r_hex;
    logic        r_break_flag;
    logic        r_break_pend;

    logic        w_shift_en;
    logic        w_par_en;
    logic        w_good;
    logic        w_err;
    logic        w_to_hit;

    // Pins idle high, so the synchronisers reset to 1 to avoid a phantom fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;
    assign w_data = r_dat_s2;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;

    // A fall landing on the terminal count wins; the timeout only fires on a quiet cycle.
    assign w_to_hit = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_state == S_IDLE) || w_to_hit) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_good      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!w_data) w_state_nxt = S_DATA;
                    else         w_err       = 1'b1;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if ((^{r_shift, r_par}) && w_data) w_good = 1'b1;
                    else                               w_err  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_to_hit) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_par        <= 1'b0;
            r_code       <= 8'h00;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_hex        <= 8'h00;
            r_break_flag <= 1'b0;
            r_break_pend <= 1'b0;
        end else begin
            r_code_valid <= w_good;
            r_frame_err  <= w_err;
            if (w_state_nxt != S_DATA) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) r_shift <= {w_data, r_shift[7:1]};
            if (w_par_en)   r_par   <= w_data;
            // F0 only arms the break marker; the display keeps the previous key.
            if (w_good) begin
                r_code <= r_shift;
                if (r_shift == 8'hF0) begin
                    r_break_pend <= 1'b1;
                end else begin
                    r_hex        <= r_shift;
                    r_break_flag <= r_break_pend;
                    r_break_pend <= 1'b0;
                end
            end
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
    assign hex_hi     = r_hex[7:4];
    assign hex_lo     = r_hex[3:0];
    assign break_flag = r_break_flag;

endmodule

// File: doc/ps2_rx_scancode.md
# ps2_rx_scancode

PS/2 keyboard receiver that deserialises device-to-host frames from the ps2_clk/ps2_data pins into 8-bit scan codes. Checks start, odd-parity and stop bits, and tracks the F0 break prefix. Holds the last make/break code as two nibbles that drive a pair of hex-to-7-segment decoders directly. Sits between the PS/2 connector pins and the display decode stage.

## Interface
- TIMEOUT_CYCLES, 50000: system-clock cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz); used only with the timeout feature.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- code  output  8  last correctly received byte, including F0 and E0.
- code_valid  output  1  one-cycle pulse when code updates.
- frame_err  output  1  one-cycle pulse on bad start, parity or stop bit, or timeout.
- hex_hi  output  4  upper nibble of last non-F0 code.
- hex_lo  output  4  lower nibble of last non-F0 code.
- break_flag  output  1  high when the held hex code was preceded by F0 (key release).

## Operation
- ps2_clk and ps2_data each pass through a 2-FF synchroniser; a third register on ps2_clk provides edge detection. fall = prev & ~cur.
- All frame activity is qualified by fall; synchronised ps2_data is sampled in the cycle fall is true.
- FSM states:
  - IDLE: on fall with data 0, go to DATA with bit_cnt=0. On fall with data 1, stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: always go to IDLE.
    - If the 8 data bits plus the parity bit hold an odd number of ones and stop=1, the frame is good: update code and pulse code_valid.
    - Otherwise pulse frame_err; code and the hex outputs are unchanged.
- Break tracking, on a good frame:
  - Byte F0: set break_pend; hex_hi, hex_lo and break_flag are unchanged.
  - Any other byte, including E0: hex_hi/hex_lo take the byte, break_flag takes break_pend, and break_pend clears.
- Back-to-back frames are accepted; no gap is required after STOP.
- code_valid and frame_err are never high in the same cycle.

## Timing
- Reset values: every output is 0 (hex outputs read 00), FSM in IDLE, break_pend 0, bit_cnt 0, timeout counter 0.
- Reset is honoured mid-frame. The partial frame is discarded, and the first fall after reset release is treated as a potential start bit.
- Pin-to-fall latency is 2–3 clk cycles.
- code, hex_hi, hex_lo, break_flag and the code_valid/frame_err pulses are registered. They appear in the cycle after the clk edge at which the STOP-state fall is seen.
- The receiver needs clk ≥ 8× the ps2_clk rate (PS/2 runs at 10–16.7 kHz).
- No backpressure: a consumer that misses the code_valid pulse loses that pulse, but code stays valid until the next good frame.

## Configuration
- PS2_RX_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter runs while the FSM is not IDLE and clears on every fall.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE, bit_cnt clears, and frame_err pulses once.
  - The counter holds at 0 in IDLE.
  - A fall in the same cycle the terminal count is reached is processed normally and takes priority; no timeout fires.
- PS2_RX_TIMEOUT_EN undefined: no counter exists, TIMEOUT_CYCLES is unused, and a truncated frame is recovered only by rst or by completing 11 edges.

## Test plan
- Frame 0x1C, parity 0, stop 1 -> code=1C with one code_valid pulse, hex_hi=1, hex_lo=C, break_flag=0, no frame_err.
- Frames F0 then 1C -> two code_valid pulses (code=F0, then 1C). hex stays at its prior value after F0, then becomes 1/C with break_flag=1. A following 0x32 gives hex 3/2 with break_flag=0.
- Frame 0x1C with parity 1 -> frame_err pulse, no code_valid, code/hex unchanged. The same with parity correct but stop 0 also gives frame_err only.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - Start plus 3 data bits, then idle -> frame_err exactly 100 cycles after the last fall, FSM back in IDLE.
  - A subsequent full 0x32 frame -> code=32 with code_valid.
- rst asserted for 2 cycles after 5 data bits of a frame -> all outputs 0 immediately. A following full 0x45 frame (parity 0) -> code=45, hex 4/5.
- Frame whose first bit is 1 (no start bit) -> frame_err pulse, FSM stays IDLE. The next valid frame decodes correctly.
